stage2_window_gen: RTL and testbench



---
 rtl/stage2_window_gen_pkg.sv | 25 ++
 rtl/stage2_window_gen_if.sv | 31 +++
 rtl/stage2_line_buffer.sv | 28 ++
 rtl/stage2_window_gen.sv | 191 +++++++++++++++++++
 tb/tb_stage2_window_gen.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stage2_window_gen_pkg.sv
// Shared constants and types for the stage-2 window generator.
// Holds the stage-2 kernel geometry, the pixel width, the input feature-map
// dimensions and the control FSM state encoding.
package stage2_window_gen_pkg;

   localparam int ST2_KX       = 5;
   localparam int ST2_KY       = 5;
   localparam int ST2_Conv_IBW = 20;
   localparam int ST2_IMG_W    = 12;
   localparam int ST2_IMG_H    = 12;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Number of full windows produced per frame.
   function automatic int win_count(input int img_w, input int img_h,
                                    input int kx, input int ky);
      return (img_h - ky + 1) * (img_w - kx + 1);
   endfunction

endpackage

// File: rtl/stage2_window_gen_if.sv
// Pixel-in / window-out bus of the stage-2 window generator.
// Optional macro ST2_WIN_INDEX_EN adds the window coordinate outputs.
interface stage2_window_gen_if #(
   parameter int IMG_W = stage2_window_gen_pkg::ST2_IMG_W,
   parameter int IMG_H = stage2_window_gen_pkg::ST2_IMG_H,
   parameter int KX    = stage2_window_gen_pkg::ST2_KX,
   parameter int KY    = stage2_window_gen_pkg::ST2_KY,
   parameter int IBW   = stage2_window_gen_pkg::ST2_Conv_IBW
);

   logic                      i_in_valid;
   logic signed [IBW-1:0]     i_in_pixel;
   logic                      o_ot_valid;
   logic [KX*KY*IBW-1:0]      o_ot_fmap;
   logic                      o_frame_done;
`ifdef ST2_WIN_INDEX_EN
   logic [$clog2(IMG_H)-1:0]  o_ot_row;
   logic [$clog2(IMG_W)-1:0]  o_ot_col;

   modport master (output i_in_valid, i_in_pixel,
                   input  o_ot_valid, o_ot_fmap, o_frame_done, o_ot_row, o_ot_col);
   modport slave  (input  i_in_valid, i_in_pixel,
                   output o_ot_valid, o_ot_fmap, o_frame_done, o_ot_row, o_ot_col);
`else
   modport master (output i_in_valid, i_in_pixel,
                   input  o_ot_valid, o_ot_fmap, o_frame_done);
   modport slave  (input  i_in_valid, i_in_pixel,
                   output o_ot_valid, o_ot_fmap, o_frame_done);
`endif

endinterface

// File: rtl/stage2_line_buffer.sv
// Single-row pixel delay: the output is the input from DEPTH accepted
// pixels earlier. Contents are not reset; the window generator never emits
// a tap before the current frame has refilled it.
module stage2_line_buffer #(
   parameter int DEPTH = 12,
   parameter int W     = 20
) (
   input  logic                clk,
   input  logic                en,
   input  logic signed [W-1:0] din,
   output logic signed [W-1:0] dout
);

   logic signed [W-1:0] mem [DEPTH];

   // Shift the whole row by one pixel per accepted input.
   always_ff @(posedge clk) begin
      if (en) begin
         mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   assign dout = mem[DEPTH-1];

endmodule

// File: rtl/stage2_window_gen.sv
// Streaming KX x KY window generator for the stage-2 convolution kernel.
// Accepts a raster-order pixel stream and emits each full window, packed as
// element (y,x) at o_ot_fmap[(y*KX+x)*IBW +: IBW], one cycle after the
// completing pixel.
// Optional macro ST2_WIN_INDEX_EN adds o_ot_row/o_ot_col (window top-left).
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no pixel of the current frame accepted yet
// ST_FILL   | rows above KY-1 being loaded, no windows possible
// ST_STREAM | windows emitted whenever a pixel completes one
// ST_DONE   | one cycle after the last pixel; drives o_frame_done
module stage2_window_gen
   import stage2_window_gen_pkg::*;
#(
   parameter int IMG_W = ST2_IMG_W,
   parameter int IMG_H = ST2_IMG_H,
   parameter int KX    = ST2_KX,
   parameter int KY    = ST2_KY,
   parameter int IBW   = ST2_Conv_IBW
) (
   input logic               clk,
   input logic               reset,
   stage2_window_gen_if.slave bus
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int FW = KX * KY * IBW;

   logic [CW-1:0]         col;
   logic [RW-1:0]         row;
   logic                  accept;
   logic                  col_last;
   logic                  row_last;
   logic                  emit;
   state_t                state;
   state_t                state_nxt;

   logic signed [IBW-1:0] lb_in [KY-1];
   logic signed [IBW-1:0] tap   [KY-1];
   logic signed [IBW-1:0] win     [KY][KX];
   logic signed [IBW-1:0] win_nxt [KY][KX];
   logic [FW-1:0]         fmap_nxt;
   logic [FW-1:0]         fmap_q;
   logic                  valid_q;

   assign accept   = bus.i_in_valid;
   assign col_last = (col == CW'(IMG_W - 1));
   assign row_last = (row == RW'(IMG_H - 1));
   // Row/col gating also keeps stale line-buffer data from a previous or
   // aborted frame out of the output.
   assign emit     = accept && (row >= RW'(KY - 1)) && (col >= CW'(KX - 1));

   // Raster position of the pixel currently presented.
   always_ff @(posedge clk) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Cascade of row delays: tap[k] is the pixel k+1 rows above the input.
   for (genvar k = 0; k < KY - 1; k++) begin : g_lb
      if (k == 0) begin : g_first
         assign lb_in[k] = bus.i_in_pixel;
      end else begin : g_next
         assign lb_in[k] = tap[k-1];
      end
      stage2_line_buffer #(
         .DEPTH (IMG_W),
         .W     (IBW)
      ) u_lb (
         .clk  (clk),
         .en   (accept),
         .din  (lb_in[k]),
         .dout (tap[k])
      );
   end

   // Next window: shift left, load the new column (oldest row at y=0),
   // and pack it in the order the kernel expects.
   always_comb begin
      win_nxt  = win;
      fmap_nxt = '0;
      if (accept) begin
         for (int y = 0; y < KY; y++) begin
            for (int x = 0; x < KX - 1; x++) begin
               win_nxt[y][x] = win[y][x+1];
            end
         end
         for (int y = 0; y < KY - 1; y++) begin
            win_nxt[y][KX-1] = tap[KY-2-y];
         end
         win_nxt[KY-1][KX-1] = bus.i_in_pixel;
      end
      for (int y = 0; y < KY; y++) begin
         for (int x = 0; x < KX; x++) begin
            fmap_nxt[(y*KX+x)*IBW +: IBW] = win_nxt[y][x];
         end
      end
   end

   // Window register.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int y = 0; y < KY; y++) begin
            for (int x = 0; x < KX; x++) begin
               win[y][x] <= '0;
            end
         end
      end else begin
         win <= win_nxt;
      end
   end

   // Output strobe and packed window; the window holds between strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         fmap_q  <= '0;
      end else begin
         valid_q <= emit;
         if (emit) begin
            fmap_q <= fmap_nxt;
         end
      end
   end

   assign bus.o_ot_valid = valid_q;
   assign bus.o_ot_fmap  = fmap_q;

`ifdef ST2_WIN_INDEX_EN
   logic [RW-1:0] row_q;
   logic [CW-1:0] col_q;

   // Top-left coordinate of the emitted window.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_q <= '0;
         col_q <= '0;
      end else if (emit) begin
         row_q <= row - RW'(KY - 1);
         col_q <= col - CW'(KX - 1);
      end
   end

   assign bus.o_ot_row = row_q;
   assign bus.o_ot_col = col_q;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state. A pixel accepted in ST_DONE is already (0,0) of the
   // next frame, because the counters wrapped on the last pixel.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_FILL;
         end
         ST_FILL: begin
            if (accept && row == RW'(KY - 1) && col == '0) state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            if (accept && row_last && col_last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = accept ? ST_FILL : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.o_frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_stage2_window_gen.sv
// Bench for stage2_window_gen: frames are described as whole images and
// every expected window is cut directly out of the image array.
module tb_stage2_window_gen;
   import stage2_window_gen_pkg::*;

   localparam int W  = ST2_IMG_W;
   localparam int H  = ST2_IMG_H;
   localparam int KX = ST2_KX;
   localparam int KY = ST2_KY;
   localparam int BW = ST2_Conv_IBW;
   localparam int FW = KX * KY * BW;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   stage2_window_gen_if bus ();

   stage2_window_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   int            img [H][W];
   int            mr, mc;
   logic [FW-1:0] last_fmap;
   int            acc_cnt, obs_win, obs_done, first_at;
   logic [FW-1:0] first_fmap, last_obs_fmap;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check_vec(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int elem(input logic [FW-1:0] f, input int y, input int x);
      logic signed [BW-1:0] e;
      e = f[(y*KX+x)*BW +: BW];
      return int'(e);
   endfunction

   task automatic fill_img(input int mode);
      int t;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            case (mode)
               0: img[r][c] = r*16 + c;
               1: img[r][c] = 1000 + r*16 + c;
               2: img[r][c] = -(r*16 + c);
               default: begin
                  t = $urandom;
                  img[r][c] = t >>> 12;
               end
            endcase
         end
      end
   endtask

   // One clock: present a pixel (or a gap), then compare the registered
   // outputs against what the image says should appear.
   task automatic cycle(input logic v);
      logic          ev, ed;
      logic [FW-1:0] ef;
      int            t;
      @(negedge clk);
      bus.i_in_valid = v;
      t = v ? img[mr][mc] : int'($urandom);
      bus.i_in_pixel = t[BW-1:0];
      ev = v && (mr >= KY-1) && (mc >= KX-1);
      ed = v && (mr == H-1) && (mc == W-1);
      if (ev) begin
         for (int y = 0; y < KY; y++) begin
            for (int x = 0; x < KX; x++) begin
               t = img[mr-KY+1+y][mc-KX+1+x];
               ef[(y*KX+x)*BW +: BW] = t[BW-1:0];
            end
         end
         last_fmap = ef;
      end else begin
         ef = last_fmap;
      end
      @(posedge clk);
      #1;
      check_bit("ot_valid", bus.o_ot_valid, ev);
      check_vec("ot_fmap", bus.o_ot_fmap, ef);
      check_bit("frame_done", bus.o_frame_done, ed);
`ifdef ST2_WIN_INDEX_EN
      if (ev) begin
         check_int("ot_row", int'(bus.o_ot_row), mr-KY+1);
         check_int("ot_col", int'(bus.o_ot_col), mc-KX+1);
      end
`endif
      if (v) acc_cnt++;
      if (bus.o_ot_valid === 1'b1) begin
         obs_win++;
         if (obs_win == 1) begin
            first_at   = acc_cnt;
            first_fmap = bus.o_ot_fmap;
         end
         last_obs_fmap = bus.o_ot_fmap;
      end
      if (bus.o_frame_done === 1'b1) obs_done++;
      if (v) begin
         if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
         end else begin
            mc++;
         end
      end
   endtask

   task automatic run_pixels(input int npix, input int gap_pct);
      acc_cnt  = 0;
      obs_win  = 0;
      obs_done = 0;
      first_at = -1;
      for (int i = 0; i < npix; i++) begin
         for (int g = 0; g < 3; g++) begin
            if ($urandom_range(99) < gap_pct) cycle(1'b0);
         end
         cycle(1'b1);
      end
   endtask

   task automatic frame_checks(input string tag);
      check_int({tag, "_windows"}, obs_win, win_count(W, H, KX, KY));
      check_int({tag, "_done_pulses"}, obs_done, 1);
      check_int({tag, "_first_at"}, first_at, (KY-1)*W + KX);
   endtask

   task automatic do_reset(input int ncyc, input logic with_valid);
      @(negedge clk);
      reset = 1'b1;
      bus.i_in_valid = with_valid;
      bus.i_in_pixel = BW'(12345);
      repeat (ncyc) @(posedge clk);
      #1;
      check_bit("rst_valid", bus.o_ot_valid, 1'b0);
      check_vec("rst_fmap", bus.o_ot_fmap, '0);
      check_bit("rst_done", bus.o_frame_done, 1'b0);
`ifdef ST2_WIN_INDEX_EN
      check_int("rst_row", int'(bus.o_ot_row), 0);
      check_int("rst_col", int'(bus.o_ot_col), 0);
`endif
      @(negedge clk);
      reset = 1'b0;
      bus.i_in_valid = 1'b0;
      mr = 0;
      mc = 0;
      last_fmap = '0;
   endtask

   initial begin
      reset = 1'b1;
      bus.i_in_valid = 1'b0;
      bus.i_in_pixel = '0;
      mr = 0;
      mc = 0;
      last_fmap = '0;

      do_reset(3, 1'b1);

      // Continuous ramp frame.
      fill_img(0);
      run_pixels(H*W, 0);
      frame_checks("ramp");
      check_int("ramp_first_el44", elem(first_fmap, 4, 4), 4*16 + 4);
      check_int("ramp_last_el00", elem(last_obs_fmap, 0, 0), 119);
      cycle(1'b0);

      // Same frame with random input gaps.
      run_pixels(H*W, 40);
      frame_checks("gaps");
      cycle(1'b0);

      // Two back-to-back frames, no idle cycle in between.
      run_pixels(H*W, 0);
      frame_checks("b2b_a");
      fill_img(1);
      run_pixels(H*W, 0);
      frame_checks("b2b_b");
      check_int("b2b_b_first_el00", elem(first_fmap, 0, 0), 1000);

      // Negative pixels.
      fill_img(2);
      run_pixels(H*W, 20);
      frame_checks("neg");
      check_int("neg_first_el12", elem(first_fmap, 1, 2), -18);

      // Random signed pixels with gaps.
      fill_img(3);
      run_pixels(H*W, 30);
      frame_checks("rand");

      // Abort mid-frame, then a fresh ramp frame.
      fill_img(1);
      run_pixels(70, 10);
      do_reset(2, 1'b1);
      fill_img(0);
      run_pixels(H*W, 0);
      frame_checks("post_rst");
      check_int("post_rst_first_el44", elem(first_fmap, 4, 4), 4*16 + 4);
      check_int("post_rst_first_el00", elem(first_fmap, 0, 0), 0);
      cycle(1'b0);
      cycle(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
